line_buffer: RTL and testbench

LINE_BUFFER -- requirements
Module: line_buffer

---
 rtl/line_buffer.sv | 64 ++++++
 tb/tb_line_buffer.sv | 116 +++++++++++
 2 files changed

// File: rtl/line_buffer.sv
// line_buffer: two-line memory producing a vertical 3-pixel column per accepted raster pixel.
module line_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pixel_in,
    input  logic             pixel_valid,
    input  logic             clear,
    input  logic [7:0]       img_width,
    input  logic [10:0]      x,
    input  logic [9:0]       y,
    output logic [WIDTH-1:0] row0,
    output logic [WIDTH-1:0] row1,
    output logic [WIDTH-1:0] row2,
    output logic [10:0]      x_reg,
    output logic [9:0]       y_reg
);
    localparam int MAX_W = 256;

    logic [WIDTH-1:0] l0 [MAX_W];
    logic [WIDTH-1:0] l1 [MAX_W];
    logic [1:0]       lines_filled;
    logic [7:0]       a;
    logic             accept, last;

    assign a      = x[7:0];
    assign accept = pixel_valid && !clear && (x < {3'b0, img_width});
    assign last   = x == ({3'b0, img_width} - 11'd1);

    // Read-before-write: the old L1 column shifts into L0 as the new pixel lands in L1
    always_ff @(posedge clk) begin
        if (accept) begin
            l0[a] <= l1[a];
            l1[a] <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row0         <= '0;
            row1         <= '0;
            row2         <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            lines_filled <= '0;
        end else if (clear) begin
            row0         <= '0;
            row1         <= '0;
            row2         <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            lines_filled <= '0;
        end else if (accept) begin
            row2  <= pixel_in;
            row1  <= (lines_filled == 2'd0) ? '0 : l1[a];
            row0  <= (lines_filled != 2'd2) ? '0 : l0[a];
            x_reg <= x;
            y_reg <= y;
            if (last && lines_filled != 2'd2)
                lines_filled <= lines_filled + 2'd1;
        end
    end
endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: scoreboard bench; driver queues expected columns, negedge monitor checks them.
module tb_line_buffer;
    logic        clk = 0, reset = 0, pixel_valid = 0, clear = 0;
    logic [7:0]  pixel_in = 0, img_width = 8;
    logic [10:0] x = 0;
    logic [9:0]  y = 0;
    logic [7:0]  row0, row1, row2;
    logic [10:0] x_reg;
    logic [9:0]  y_reg;

    typedef struct {
        logic [7:0]  r0, r1, r2;
        logic [10:0] xr;
        logic [9:0]  yr;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc = 0, checks = 0, fails = 0;

    line_buffer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .clear(clear), .img_width(img_width), .x(x), .y(y),
        .row0(row0), .row1(row1), .row2(row2), .x_reg(x_reg), .y_reg(y_reg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (q.size() != 0 && q[0].due < cyc) begin
            checks++; fails++;
            $display("FAIL missed_check due=%0d now=%0d", q[0].due, cyc);
            void'(q.pop_front());
        end
        if (q.size() != 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({row0, row1, row2, x_reg, y_reg} !== {e.r0, e.r1, e.r2, e.xr, e.yr}) begin
                fails++;
                $display("FAIL column@%0d got r0=%0d r1=%0d r2=%0d x=%0d y=%0d want r0=%0d r1=%0d r2=%0d x=%0d y=%0d",
                         cyc, row0, row1, row2, x_reg, y_reg, e.r0, e.r1, e.r2, e.xr, e.yr);
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({row0, row1, row2, x_reg, y_reg} !== '0) begin
            fails++;
            $display("FAIL %s got r0=%0d r1=%0d r2=%0d x=%0d y=%0d want all 0", name, row0, row1, row2, x_reg, y_reg);
        end
    endtask

    task automatic step(input logic v, input logic c, input logic [7:0] px,
                        input logic [10:0] xx, input logic [9:0] yy, input exp_t e);
        pixel_valid = v; clear = c; pixel_in = px; x = xx; y = yy;
        e.due = cyc + 1;
        q.push_back(e);
        cur = e;
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.r2 = 8'(k + base);
            e.r1 = (k >= 8) ? 8'(k - 8 + base) : 8'd0;
            e.r0 = (k >= 16) ? 8'(k - 16 + base) : 8'd0;
            e.xr = 11'(k % 8);
            e.yr = 10'(k / 8);
            step(1, 0, 8'(k + base), 11'(k % 8), 10'(k / 8), e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain_timeout pending=%0d want 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t z;
        z = '{r0: 0, r1: 0, r2: 0, xr: 0, yr: 0, due: 0};
        repeat (2) @(posedge clk);
        #1 check_zero("reset_state");
        reset = 1;
        @(posedge clk); #1;
        step(0, 1, 0, 0, 0, z);
        stream(32, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'hAA, 11'd3, 10'd5, cur);
        step(0, 1, 0, 0, 0, z);
        step(1, 0, 8'd77, 11'd9, 10'd0, z);
        step(1, 1, 8'd55, 11'd0, 10'd0, z);
        step(0, 0, 0, 0, 0, z);
        stream(20, 1);
        pixel_valid = 0;
        drain();
        #2 reset = 0;
        #1 check_zero("async_reset");
        @(posedge clk); #1;
        check_zero("reset_held");
        reset = 1;
        stream(16, 101);
        pixel_valid = 0;
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
